// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one load/store at a time, fixed LATENCY wait, one-cycle response pulse.
// Latency: rvalid LATENCY+1 cycles after acceptance. Backpressure: ready low from acceptance until the response retires; there is no queueing.
// Optional DMEM_ADDR_CHECK_EN adds err_o and suppresses misaligned or out-of-range accesses.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
`ifdef DMEM_ADDR_CHECK_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic          bad;
    } hdr_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    hdr_t        hold_q, hold_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem [DEPTH];

    hdr_t        in_hdr;
    hdr_t        acc_hdr;
    logic        commit;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    always_comb begin
        in_hdr       = '0;
        in_hdr.we    = we_i;
        in_hdr.idx   = addr_i[AW+1:2];
        in_hdr.wdata = wdata_i;
`ifdef DMEM_ADDR_CHECK_EN
        in_hdr.bad   = (addr_i[1:0] != 2'b00) || ((addr_i >> (AW + 2)) != 32'd0);
`else
        in_hdr.bad   = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req_i && !rst_i) begin
                    hold_d = in_hdr;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=0 the array is accessed on the acceptance edge itself, before hold_q is loaded.
    assign acc_hdr = (state_q == IDLE) ? in_hdr : hold_q;
    assign commit  = !rst_i && (state_q != RESP) && (state_d == RESP);

    always_comb begin
        rdata_d = rdata_q;
        if (commit && !acc_hdr.we) begin
            rdata_d = acc_hdr.bad ? 32'd0 : mem[acc_hdr.idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && acc_hdr.we && !acc_hdr.bad) begin
            mem[acc_hdr.idx] <= acc_hdr.wdata;
        end
    end

    assign ready_o  = (state_q == IDLE) && !rst_i;
    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rdata_q;
`ifdef DMEM_ADDR_CHECK_EN
    assign err_o    = (state_q == RESP) && hold_q.bad;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder for the ARM core's load/store port. It accepts one read or write request at a time through a req/ready handshake and waits a configurable number of cycles. It then returns a single-cycle response pulse carrying read data or write completion. It sits between the core's data-side outputs (ALUResult as address, WriteData, MemWrite) and its ReadData input, and replaces the zero-latency dmem for multicycle and stall-capable core variants.

## Interface

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, ≥2.
- LATENCY, 2: wait cycles between acceptance and response; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid; sampled only when ready=1.
- we  in  1  1 = write (MemWrite), 0 = read.
- addr  in  32  byte address (ALUResult).
- wdata  in  32  write data (WriteData).
- ready  out  1  responder idle and accepting a request this cycle.
- rvalid  out  1  one-cycle response pulse.
- rdata  out  32  read data; valid when rvalid=1 and the request was a read.
- err  out  1  address error, qualified by rvalid; present only with DMEM_ADDR_CHECK_EN.

## Operation

- FSM states:
  - IDLE, reset state. ready=1.
  - WAIT, counting LATENCY cycles.
  - RESP, lasting exactly one cycle. rvalid=1.
- Acceptance occurs when req & ready are high in cycle T. On that edge the block captures we, addr and wdata into holding registers. Inputs after acceptance are ignored.
- Transitions after acceptance:
  - IDLE→WAIT if LATENCY>0, loading the counter with LATENCY-1.
  - IDLE→RESP if LATENCY=0.
  - WAIT decrements the counter and goes to RESP when the counter is 0.
  - RESP→IDLE unconditionally.
- Word index is captured addr[AW+1:2], with AW = clog2(DEPTH).
- Array access happens on the edge entering RESP:
  - Write: mem[index] ← wdata.
  - Read: rdata ← mem[index].
  - A read of a just-written word therefore always returns the new value.
- rdata holds its value until the next read response. A write response leaves rdata unchanged.
- ready=0 in WAIT and RESP. req is ignored there; there is no queueing.
- Memory array contents are not reset. Only control state and output registers are reset.

## Timing

- Values during and after reset:
  - ready=0 while rst is high. ready=1 from the first cycle after deassertion.
  - rvalid=0, rdata=0, err=0. State IDLE, counter 0.
- Latency: request accepted in cycle T, so rvalid=1 in cycle T+1+LATENCY.
- Throughput: at most one request per LATENCY+2 cycles. ready returns high in cycle T+2+LATENCY.
- Reset mid-operation (rst asserted in WAIT or RESP):
  - The pending request is dropped and no rvalid is produced.
  - A pending write is not committed if rst rises before the commit edge.
- Address wrap without checking: bits above AW+1 and bits [1:0] are ignored. addr 4·DEPTH aliases word 0.

## Configuration

- DMEM_ADDR_CHECK_EN defined:
  - err port exists.
  - At acceptance, addr[1:0]≠0 or addr ≥ 4·DEPTH marks the request bad.
  - A bad request completes with normal timing: rvalid=1, err=1.
  - A bad write is suppressed. A bad read returns rdata=0.
  - err=0 on good responses and whenever rvalid=0.
- DMEM_ADDR_CHECK_EN undefined:
  - err port absent.
  - All addresses accepted and wrapped/truncated as above. No suppression.

## Test plan

- Write 0xDEADBEEF to 0x10 accepted in cycle 0 (LATENCY=2), then read 0x10 → write response rvalid in cycle 3; read accepted cycle 4, rvalid cycle 7 with rdata=0xDEADBEEF.
- LATENCY=0, req held high with reads of 0x0 then 0x4 (words preloaded 0x11, 0x22) → rvalid in cycles 1 and 3, rdata 0x11 then 0x22, ready=0 in cycles 1 and 3.
- req held high continuously for 20 cycles, LATENCY=2 → exactly 5 acceptances (cycles 0, 4, 8, 12, 16), each with one rvalid pulse.
- DEPTH=64, write 0x5 to 0x100 then read 0x0:
  - Without macro → read returns 0x5.
  - With macro → write response has err=1, read of 0x0 returns prior value, err=0.
- Read from 0x12 with word 4 = 0xA5:
  - With macro → rvalid=1, err=1, rdata=0.
  - Without macro → rdata=0xA5.
- Write 0x77 to 0x8 accepted in cycle 0, rst pulsed in cycle 1 → no rvalid, ready=1 after release, subsequent read of 0x8 returns the pre-test value.
